apb_arb_master: RTL

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_master.sv | 105 ++++++++++
 1 files changed

// File: rtl/apb_arb_master.sv
// apb_arb_master: two-requester round-robin arbiter driving a single APB master port.
module apb_arb_master #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_err0,
  output logic                  o_err1,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PWRITE,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic                  i_PSLVERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last, gnt, cand0, cand1, pick, done;
  // a requester still seeing its ack is dropping its request, so skip it
  always_comb begin
    cand0 = i_req0 & ~o_ack0;
    cand1 = i_req1 & ~o_ack1;
    pick  = (cand0 & cand1) ? ~last : cand1;
    done  = i_PREADY | (wait_cnt == CW'(TIMEOUT - 1));
  end
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      last      <= 1'b1;
      gnt       <= 1'b0;
      o_ack0    <= 1'b0;
      o_ack1    <= 1'b0;
      o_err0    <= 1'b0;
      o_err1    <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
      o_PADDR   <= '0;
      o_PWRITE  <= 1'b0;
      o_PSEL    <= 1'b0;
      o_PENABLE <= 1'b0;
      o_PWDATA  <= '0;
    end else begin
      o_ack0 <= 1'b0;
      o_ack1 <= 1'b0;
      o_err0 <= 1'b0;
      o_err1 <= 1'b0;
      case (state)
        IDLE: if (cand0 | cand1) begin
          gnt       <= pick;
          o_PADDR   <= pick ? i_addr1 : i_addr0;
          o_PWRITE  <= pick ? i_we1 : i_we0;
          o_PWDATA  <= pick ? i_wdata1 : i_wdata0;
          o_PSEL    <= 1'b1;
          o_PENABLE <= 1'b0;
          wait_cnt  <= '0;
          state     <= SETUP;
        end
        SETUP: begin
          o_PENABLE <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: if (done) begin
          // a timeout completes with err set and leaves rdata untouched
          if (gnt) begin
            o_ack1 <= 1'b1;
            o_err1 <= ~i_PREADY | i_PSLVERR;
            if (i_PREADY & ~o_PWRITE) o_rdata1 <= i_PRDATA;
          end else begin
            o_ack0 <= 1'b1;
            o_err0 <= ~i_PREADY | i_PSLVERR;
            if (i_PREADY & ~o_PWRITE) o_rdata0 <= i_PRDATA;
          end
          o_PSEL    <= 1'b0;
          o_PENABLE <= 1'b0;
          last      <= gnt;
          state     <= IDLE;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
